// File: rtl/serial_checking_sink.sv
// Local-port serial sink: deserialises start-bit framed flits, checks packet framing and
// destination, keeps saturating counters and drives LFSR backpressure. Option: SINK_SEQ_CHECK_EN.
module serial_checking_sink #(
  parameter int ID        = 0,
  parameter int HOSP      = 255,
  parameter int FLIT_W    = 16,
  parameter int NUM_NODES = 9
) (
  input  logic        clk,
  input  logic        reset,
  output logic        busy,
  input  logic        data,
  output logic [19:0] pkt_count,
  output logic [19:0] flit_count,
  output logic [15:0] err_count,
  output logic        pkt_done,
  output logic [3:0]  pkt_src,
  output logic [7:0]  pkt_len,
  output logic [15:0] seq_err_count
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  localparam logic [7:0] LFSR_RAW  = {4'b0000, 4'(ID)} ^ 8'hA5;
  localparam logic [7:0] LFSR_SEED = (LFSR_RAW == 8'h00) ? 8'h01 : LFSR_RAW;
  localparam logic [7:0] HOSP_B    = 8'(HOSP);
  localparam bit         HOSP_ZERO = (HOSP == 0);
  localparam int         CNT_W     = $clog2(FLIT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FLIT_W - 1);
  localparam logic [3:0] MY_ID     = 4'(ID);

  state_t              r_state, w_state_next;
  logic [7:0]          r_lfsr;
  logic                r_busy, w_busy_next;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [FLIT_W-2:0]   r_shift;
  logic                r_in_pkt;
  logic [7:0]          r_len;
  logic [3:0]          r_cur_src;
  logic [19:0]         r_pkt_count, r_flit_count;
  logic [15:0]         r_err_count;
  logic                r_pkt_done;
  logic [3:0]          r_pkt_src;
  logic [7:0]          r_pkt_len;
  logic                w_last_bit;

  // The flit is decoded on the edge that samples its last bit, so results are visible in CHECK.
  logic [FLIT_W-1:0]   w_flit;
  logic [1:0]          w_type;
  logic [3:0]          w_dest, w_src;
  logic [5:0]          w_seq;
  logic                w_src_ok, w_good_head, w_err;
  logic [7:0]          w_len_inc;

  assign w_flit    = {data, r_shift};
  assign w_type    = w_flit[15:14];
  assign w_dest    = w_flit[13:10];
  assign w_src     = w_flit[9:6];
  assign w_seq     = w_flit[5:0];
  assign w_len_inc = (r_len == 8'hFF) ? r_len : r_len + 8'd1;

`ifdef SINK_SEQ_CHECK_EN
  assign w_src_ok = ({1'b0, w_src} < 5'(NUM_NODES));
`else
  assign w_src_ok = 1'b1;
`endif

  assign w_good_head = (w_type == 2'b01) && (w_dest == MY_ID) && w_src_ok;

  always_comb begin
    w_err = 1'b0;
    case (w_type)
      2'b01:   w_err = r_in_pkt || !w_good_head;
      2'b10,
      2'b11:   w_err = !r_in_pkt;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy_next  = 1'b1;
    w_last_bit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_next = HOSP_ZERO ? 1'b1 : (r_lfsr > HOSP_B);
        if (data) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_bitcnt == LAST_BIT) begin
          w_last_bit   = 1'b1;
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr       <= LFSR_SEED;
      r_busy       <= 1'b1;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_in_pkt     <= 1'b0;
      r_len        <= '0;
      r_cur_src    <= '0;
      r_pkt_count  <= '0;
      r_flit_count <= '0;
      r_err_count  <= '0;
      r_pkt_done   <= 1'b0;
      r_pkt_src    <= '0;
      r_pkt_len    <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_busy     <= w_busy_next;
      r_pkt_done <= 1'b0;
      if (r_state == S_IDLE) r_bitcnt <= '0;
      if (r_state == S_SHIFT) begin
        r_shift  <= w_flit[FLIT_W-1:1];
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_last_bit) begin
        if (r_flit_count != '1) r_flit_count <= r_flit_count + 20'd1;
        if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + 16'd1;
        case (w_type)
          2'b01: begin
            // A head always ends any open packet; only a good one opens a new packet.
            r_in_pkt <= w_good_head;
            if (w_good_head) begin
              r_len     <= 8'd1;
              r_cur_src <= w_src;
            end
          end
          2'b10: if (r_in_pkt) r_len <= w_len_inc;
          2'b11: begin
            if (r_in_pkt) begin
              r_in_pkt   <= 1'b0;
              r_len      <= w_len_inc;
              r_pkt_src  <= r_cur_src;
              r_pkt_len  <= w_len_inc;
              r_pkt_done <= 1'b1;
              if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + 20'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SINK_SEQ_CHECK_EN
  logic [5:0]           r_exp_seq [NUM_NODES];
  logic [NUM_NODES-1:0] r_seq_valid;
  logic [15:0]          r_seq_err_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NODES; i++) r_exp_seq[i] <= '0;
      r_seq_valid     <= '0;
      r_seq_err_count <= '0;
    end else if (w_last_bit && w_good_head) begin
      if (r_seq_valid[w_src] && (w_seq != r_exp_seq[w_src]) && (r_seq_err_count != '1))
        r_seq_err_count <= r_seq_err_count + 16'd1;
      r_exp_seq[w_src]   <= w_seq + 6'd1;
      r_seq_valid[w_src] <= 1'b1;
    end
  end

  assign seq_err_count = r_seq_err_count;
`else
  logic w_seq_unused;
  assign w_seq_unused  = ^{w_seq, 5'(NUM_NODES)};
  assign seq_err_count = 16'd0;
`endif

  assign busy       = r_busy;
  assign pkt_count  = r_pkt_count;
  assign flit_count = r_flit_count;
  assign err_count  = r_err_count;
  assign pkt_done   = r_pkt_done;
  assign pkt_src    = r_pkt_src;
  assign pkt_len    = r_pkt_len;

endmodule

// File: doc/serial_checking_sink.md
Name: serial_checking_sink

Overview:
- Local-port consumer at each mesh node. Sits directly downstream of the router's local output port, in place of a plain sink.
- Deserialises single-wire flits from the router and reassembles head/body/tail packets.
- Checks that each packet's destination matches this node, and checks flit framing.
- Exposes saturating packet, flit and error counters to the bench.
- Applies pseudo-random backpressure set by a hospitality parameter.

Parameters:
ID, 0, node address of this sink; compared against the head flit's dest field
HOSP, 255, hospitality 0-255; 255 = never busy, 0 = permanently busy
FLIT_W, 16, serial flit width in bits
NUM_NODES, 9, source count; sizes the sequence table for the optional feature

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
busy  out  1  backpressure to the router local tx; registered
data  in  1  serial flit line from the router
pkt_count  out  20  good packets received, saturating
flit_count  out  20  flits received, all types, saturating
err_count  out  16  framing/address errors, saturating
pkt_done  out  1  one-cycle pulse when a good tail is accepted
pkt_src  out  4  src field of the last good packet
pkt_len  out  8  flit count of the last good packet, head through tail, saturating at 255
seq_err_count  out  16  sequence errors; held 0 when the feature is off

Behaviour:
- Reset (reset low, async):
  - state=IDLE, busy=1.
  - All counters 0; pkt_done=0; pkt_src=0; pkt_len=0.
  - in_pkt=0.
  - LFSR = {4'b0, ID[3:0]} ^ 8'hA5, forced to 8'h01 if the result is 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle out of reset.
- Serial format:
  - Idle line is 0.
  - A flit is one start bit (1), then FLIT_W data bits LSB first, one bit per cycle.
- States:
  - IDLE:
    - busy <= (HOSP==0) ? 1 : (lfsr > HOSP).
    - data==1 -> SHIFT with bit counter 0. This is accepted regardless of the current busy value.
  - SHIFT:
    - Shift data in each cycle; busy <= 1.
    - After FLIT_W bits -> CHECK.
  - CHECK:
    - Exactly one cycle; busy <= 1.
    - Decode the flit, update counters, then go to IDLE.
- Minimum flit period is FLIT_W+2 cycles. busy is held 1 through SHIFT and CHECK, so the sender sees busy before its next start bit.
- Flit decode, bits [15:14]:
  - 01 head: dest [13:10], src [9:6], seq [5:0].
  - 10 body.
  - 11 tail.
  - 00 invalid.
- flit_count increments in CHECK for every flit, including erroneous ones.
- Error rules: err_count +1 and the flit is dropped from the packet in these cases.
  - Head while in_pkt: the old packet is abandoned and the new head is adopted.
  - Body/tail while !in_pkt.
  - Head with dest != ID: in_pkt stays 0.
  - Type 00.
- Good head: in_pkt=1, latch src and seq, length counter = 1.
- Body while in_pkt: length +1.
- Tail while in_pkt: length +1, in_pkt=0.
  - pkt_count +1; pkt_src and pkt_len updated.
  - pkt_done=1 for exactly the CHECK cycle, registered. It is observed the cycle after the tail's last data bit.
- All counters saturate at all-ones; no wrap.
- Reset asserted mid-flit or mid-packet: the partial flit/packet is discarded with no error counted, and all reset values apply.

Optional Feature:
Macro SINK_SEQ_CHECK_EN.
- Defined:
  - NUM_NODES-entry table of 6-bit expected sequence numbers, plus a valid bit per entry; all cleared on reset.
  - On a good head from src s with entry valid and seq != expected[s]: seq_err_count +1 (saturating).
  - In every good-head case, expected[s] <= seq+1 mod 64 and valid[s]=1.
  - src >= NUM_NODES counts as an error in err_count.
- Undefined: no table is built; seq_err_count tied to 0.

Test Plan:
- Reset release, HOSP=255, line idle -> busy=0 by the 2nd cycle; all counters 0; pkt_done never pulses.
- ID=4: head(dest4,src2,seq0), body, tail; each flit sent 1 cycle after busy is seen low -> pkt_count=1, flit_count=3, pkt_len=3, pkt_src=2, err_count=0; pkt_done pulses once, 1 cycle after the tail's last bit.
- ID=4: head with dest=5, then body, tail -> err_count=3, pkt_count=0, flit_count=3.
- Head, head, tail (all dest ID, src 1) -> err_count=1, pkt_count=1, pkt_len=2.
- HOSP=0 -> busy stays 1 forever. Force 255 heads while busy: each is still accepted; flit_count=255.
- Reset pulsed during bit 7 of a tail -> no pkt_done; counters 0. A subsequent good 2-flit packet gives pkt_count=1.
- With SINK_SEQ_CHECK_EN: src 3 sends seq 5 then seq 7 -> seq_err_count=1.
